// File: rtl/mips_bus_mem_responder.sv
// mips_bus_mem_responder: wait-state memory responder for the CPU bus (ports: clk, reset, address, read, write, byteenable, writedata -> waitrequest, readdata, protocol_error)
module mips_bus_mem_responder #(
  parameter int DEPTH = 64,
  parameter int WAIT_STATES = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        protocol_error
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2;
  localparam logic [31:0] IBASE = 32'hBFC0_0000;
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);
  localparam int AW = $clog2(2 * DEPTH);
  logic [1:0] state;
  logic [3:0] cnt;
  logic [31:0] addr_q, wdata_q, a, m;
  logic [3:0] be_q, b;
  logic rd_q, wr_q, wr_eff, req, in_d, in_i, hit, chg, last, enter_ack;
  logic [29:0] ioff;
  logic [AW-1:0] idx;
  logic [31:0] mem [2*DEPTH];
  always_comb begin
    req = read | write;
    a = state == IDLE ? address : addr_q;
    b = state == IDLE ? byteenable : be_q;
    wr_eff = state == IDLE ? write : wr_q;
    m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    ioff = a[31:2] - IBASE[31:2];
    in_d = a < SPAN;
    in_i = a >= IBASE && ioff < 30'(DEPTH);
    hit = a[1:0] == 2'b00 && (in_d || in_i);
    idx = in_d ? AW'(a[31:2]) : AW'(DEPTH) + AW'(ioff);
    chg = {address, byteenable, writedata, read, write} != {addr_q, be_q, wdata_q, rd_q, wr_q};
    last = state == IDLE ? WAIT_STATES == 1 : 5'(cnt) + 5'd1 == 5'(WAIT_STATES);
    enter_ack = req && last && state != ACK;
    waitrequest = state == IDLE ? req : state == WAIT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      readdata <= 32'd0;
      protocol_error <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        addr_q <= address;
        be_q <= byteenable;
        wdata_q <= writedata;
        rd_q <= read;
        wr_q <= write;
        cnt <= 4'd1;
        state <= last ? ACK : WAIT;
        if (!hit || (read && write)) protocol_error <= 1'b1;
      end else if (state == WAIT) begin
        state <= !req ? IDLE : last ? ACK : WAIT;
        cnt <= cnt + 4'd1;
        if (!req || chg) protocol_error <= 1'b1;
      end else if (state == ACK) begin
        state <= IDLE;
      end
      if (enter_ack && !wr_eff) readdata <= hit ? mem[idx] & m : 32'd0;
    end
  end
  always_ff @(posedge clk)
    if (!reset && state == ACK && wr_q && hit)
      for (int i = 0; i < 4; i++)
        if (be_q[i]) mem[idx][8*i+:8] <= wdata_q[8*i+:8];
endmodule

// File: tb/tb_mips_bus_mem_responder.sv
// tb_mips_bus_mem_responder: bench for the responder at 1, 3 and 4 wait states
module tb_mips_bus_mem_responder;
  localparam int D = 16;
  localparam logic [31:0] IB = 32'hBFC0_0000;
  logic clk = 0, reset = 1;
  logic [31:0] address [3], writedata [3], readdata [3];
  logic read [3], write [3], waitrequest [3], protocol_error [3];
  logic [3:0] byteenable [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mips_bus_mem_responder #(.DEPTH(D), .WAIT_STATES(g == 0 ? 1 : g == 1 ? 3 : 4), .INIT_FILE("")) dut (
      .clk(clk), .reset(reset), .address(address[g]), .read(read[g]), .write(write[g]),
      .byteenable(byteenable[g]), .writedata(writedata[g]), .waitrequest(waitrequest[g]),
      .readdata(readdata[g]), .protocol_error(protocol_error[g]));
  end
  int n_chk = 0, n_fail = 0;
  bit ev = 0;
  logic ew [3], me [3], ec [3];
  logic [31:0] erd [3];
  logic [31:0] mm [3][2*D];
  function automatic int ws(int k);
    return k == 0 ? 1 : k == 1 ? 3 : 4;
  endfunction
  function automatic bit ok(logic [31:0] a);
    return a[1:0] == 2'b00 && (a < 4 * D || (a >= IB && a < IB + 4 * D));
  endfunction
  function automatic int widx(logic [31:0] a);
    return a < 4 * D ? int'(a / 4) : D + int'((a - IB) / 4);
  endfunction
  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %h, expected %h", nm, k, $time, act, exp);
    end
  endtask
  always @(negedge clk)
    if (ev)
      for (int k = 0; k < 3; k++) begin
        chk("waitrequest", k, 32'(waitrequest[k]), 32'(ew[k]));
        chk("protocol_error", k, 32'(protocol_error[k]), 32'(me[k]));
        if (ec[k]) chk("readdata", k, readdata[k], erd[k]);
      end
  task automatic nx();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(int k, bit rd, bit wr, logic [31:0] a, logic [3:0] be, logic [31:0] wd);
    read[k] = rd; write[k] = wr; address[k] = a; byteenable[k] = be; writedata[k] = wd;
    ew[k] = rd | wr;
  endtask
  task automatic idle(int k);
    read[k] = 0; write[k] = 0; ew[k] = 0;
    nx();
  endtask
  task automatic access(int k, bit rd, bit wr, logic [31:0] a, logic [3:0] be, logic [31:0] wd,
                        bit hl = 0, logic [31:0] lit = 0);
    logic [31:0] m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    bit g = ok(a);
    drive(k, rd, wr, a, be, wd);
    nx();
    if (!g || (rd && wr)) me[k] = 1;
    repeat (ws(k) - 1) nx();
    ew[k] = 0;
    if (rd && !wr) begin
      erd[k] = g ? mm[k][widx(a)] & m : 32'd0;
      ec[k] = 1;
      if (hl) begin
        @(negedge clk);
        chk("lit_readdata", k, readdata[k], lit);
      end
    end
    nx();
    ec[k] = 0;
    if (wr && g) mm[k][widx(a)] = (mm[k][widx(a)] & ~m) | (wd & m);
    ew[k] = read[k] | write[k];
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int k = 0; k < 3; k++) begin
      drive(k, 0, 0, 0, 0, 0);
      me[k] = 0; ec[k] = 0; erd[k] = 0;
    end
    nx(); nx();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_waitrequest", k, 32'(waitrequest[k]), 0);
      chk("rst_readdata", k, readdata[k], 0);
      chk("rst_protocol_error", k, 32'(protocol_error[k]), 0);
    end
    nx();
    reset = 0;
    ev = 1;
    for (int k = 0; k < 3; k++) begin
      access(k, 0, 1, 32'h0, 4'hF, 32'h1122_3344); idle(k);
      access(k, 0, 1, 32'h4, 4'hF, 32'h5566_7788); idle(k);
      access(k, 0, 1, 32'h8, 4'hF, 32'h1122_3344); idle(k);
      access(k, 0, 1, 32'h10, 4'hF, 32'h0102_0304); idle(k);
    end
    access(0, 0, 1, IB, 4'hF, 32'h2402_0005); idle(0);
    access(0, 1, 0, 32'h0, 4'hF, 0, 1, 32'h1122_3344); idle(0);
    access(1, 0, 1, 32'h8, 4'b0101, 32'hAABB_CCDD); idle(1);
    access(1, 1, 0, 32'h8, 4'hF, 0, 1, 32'h11BB_33DD); idle(1);
    drive(1, 1, 0, 32'h0, 4'hF, 0);
    nx();
    read[1] = 0;
    nx();
    me[1] = 1; ew[1] = 0;
    @(negedge clk);
    chk("lit_drop_readdata", 1, readdata[1], 32'h11BB_33DD);
    chk("lit_drop_error", 1, 32'(protocol_error[1]), 1);
    nx();
    access(0, 1, 0, 32'h0, 4'hF, 0, 1, 32'h1122_3344);
    access(0, 1, 0, 32'h4, 4'hF, 0, 1, 32'h5566_7788);
    idle(0);
    access(0, 1, 0, IB, 4'hF, 0, 1, 32'h2402_0005); idle(0);
    access(0, 1, 0, IB + 4 * D, 4'hF, 0, 1, 32'h0); idle(0);
    access(0, 1, 1, 32'h8, 4'hF, 32'hCAFE_F00D); idle(0);
    access(0, 1, 0, 32'h8, 4'hF, 0, 1, 32'hCAFE_F00D); idle(0);
    access(0, 1, 0, 32'h8, 4'b0110, 0, 1, 32'h00FE_F000); idle(0);
    access(2, 0, 1, 32'h0, 4'h0, 32'hFFFF_FFFF); idle(2);
    access(2, 1, 0, 32'h0, 4'hF, 0, 1, 32'h1122_3344); idle(2);
    access(2, 1, 0, 32'h0, 4'h0, 0, 1, 32'h0); idle(2);
    drive(2, 0, 1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    nx();
    nx();
    reset = 1;
    nx();
    reset = 0;
    write[2] = 0; ew[2] = 0;
    for (int k = 0; k < 3; k++) me[k] = 0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("lit_midreset_readdata", k, readdata[k], 0);
      chk("lit_midreset_waitrequest", k, 32'(waitrequest[k]), 0);
    end
    nx();
    access(2, 1, 0, 32'h10, 4'hF, 0, 1, 32'h0102_0304); idle(2);
    drive(1, 1, 0, 32'h0, 4'hF, 0);
    nx();
    address[1] = 32'h4;
    nx();
    me[1] = 1;
    nx();
    ew[1] = 0; erd[1] = 32'h1122_3344; ec[1] = 1;
    @(negedge clk);
    chk("lit_change_readdata", 1, readdata[1], 32'h1122_3344);
    nx();
    ec[1] = 0;
    idle(1);
    reset = 1;
    nx();
    reset = 0;
    for (int k = 0; k < 3; k++) me[k] = 0;
    access(1, 1, 0, 32'h2, 4'hF, 0, 1, 32'h0); idle(1);
    repeat (5) nx();
    @(negedge clk);
    chk("lit_sticky_error", 1, 32'(protocol_error[1]), 1);
    nx();
    reset = 1;
    nx();
    reset = 0;
    for (int k = 0; k < 3; k++) me[k] = 0;
    @(negedge clk);
    chk("lit_error_cleared", 1, 32'(protocol_error[1]), 0);
    nx();
    ev = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
